// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Sequencing FSM for a multicycle MIPS datapath. It steps each instruction
// through fetch / decode / execute / memory / writeback. It drives every mux
// select and write strobe, and waits on a memory ready handshake with a
// bounded timeout.
//
// Optional feature macro: JAL_JR_EN
//   defined   : jal (opcode 000011) and jr (R-type, funct 001000) are supported
//   undefined : jal decodes as illegal; jr runs through the normal R-type path
//
// Parameters
//   WAIT_LIMIT  max cycles spent waiting on mem_ready in one memory state (>=1)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   opcode[5:0]  in   decoded opcode (stable from DECODE to next fetch)
//   funct[5:0]   in   decoded funct
//   zero         in   ALU zero flag
//   mem_ready    in   memory completes the access this cycle
//   pc_write     out  PC load strobe
//   ir_write     out  instruction register load
//   iord         out  memory address select: 0=PC, 1=ALUOut
//   mem_read     out  memory read request
//   mem_write    out  memory write request
//   reg_write    out  regfile write
//   reg_dst      out  00=rt, 01=rd, 10=$31
//   mem_to_reg   out  00=ALUOut, 01=MDR, 10=PC
//   alu_src_a    out  0=PC, 1=A
//   alu_src_b    out  00=B, 01=4, 10=signext, 11=signext<<2
//   alu_op       out  00=add, 01=sub, 10=per funct
//   pc_source    out  00=ALU result, 01=ALUOut, 10=jump target, 11=A
//   illegal_op   out  one-cycle pulse on an unknown opcode
//   bus_error    out  one-cycle pulse on a memory timeout
//   state        out  current state encoding (debug)
//   instr_count  out  retired instruction count, wraps
//
// state      | meaning
// -----------+-----------------------------------------------------------
// FETCH   0  | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE  1  | dispatch on opcode, precompute branch target
// MEM_ADDR 2 | compute load/store address
// MEM_READ 3 | data read, wait on mem_ready
// MEM_WB  4  | write loaded data to rt
// MEM_WRITE 5| data write, wait on mem_ready
// R_EXEC  6  | R-type ALU operation
// R_WB    7  | write ALU result to rd
// BRANCH  8  | compare, conditional PC load (beq/bne)
// JUMP    9  | PC <= jump target
// I_EXEC 10  | addi ALU operation
// I_WB   11  | write ALU result to rt
// JAL    12  | $31 <= PC, PC <= jump target
// JR     13  | PC <= A
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int WAIT_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        illegal_op,
    output logic        bus_error,
    output logic [3:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

`ifdef JAL_JR_EN
    localparam bit JAL_JR_ON = 1'b1;
`else
    localparam bit JAL_JR_ON = 1'b0;
`endif

    localparam int              CW        = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0]   WAIT_LAST = CW'(WAIT_LIMIT - 1);

    state_t          cur_state;
    state_t          nxt_state;
    logic [CW-1:0]   wait_cnt;
    logic [CW-1:0]   wait_nxt;
    logic            retire;
    logic            in_mem_state;
    logic            mem_stall;
    logic            timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state   <= S_FETCH;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= wait_nxt;
            if (retire) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end

    // The wait counter only runs while a memory state is stalled; any exit
    // (completion or timeout) returns it to zero.
    always_comb begin
        in_mem_state = (cur_state == S_FETCH) || (cur_state == S_MEM_READ) ||
                       (cur_state == S_MEM_WRITE);
        mem_stall    = in_mem_state && !mem_ready;
        timeout_hit  = mem_stall && (wait_cnt == WAIT_LAST);
        wait_nxt     = (mem_stall && !timeout_hit) ? (wait_cnt + CW'(1)) : '0;
    end

    always_comb begin
        nxt_state  = cur_state;
        retire     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        illegal_op = 1'b0;
        bus_error  = 1'b0;

        case (cur_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    nxt_state = S_DECODE;
                end else if (timeout_hit) begin
                    // Retry the same PC: nothing was written.
                    bus_error = 1'b1;
                    nxt_state = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    nxt_state = S_MEM_ADDR;
                end else if (opcode == OP_RTYPE) begin
                    nxt_state = (JAL_JR_ON && funct == FN_JR) ? S_JR : S_R_EXEC;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    nxt_state = S_BRANCH;
                end else if (opcode == OP_J) begin
                    nxt_state = S_JUMP;
                end else if (opcode == OP_ADDI) begin
                    nxt_state = S_I_EXEC;
                end else if (JAL_JR_ON && opcode == OP_JAL) begin
                    nxt_state = S_JAL;
                end else begin
                    illegal_op = 1'b1;
                    nxt_state  = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    nxt_state = S_MEM_WB;
                end else if (timeout_hit) begin
                    bus_error = 1'b1;
                    nxt_state = S_FETCH;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                retire     = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    nxt_state = S_FETCH;
                end else if (timeout_hit) begin
                    bus_error = 1'b1;
                    nxt_state = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt_state = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 from fetch, so it is the link value.
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                retire     = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_JR: begin
                pc_source = 2'b11;
                pc_write  = 1'b1;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            default: begin
                nxt_state = S_FETCH;
            end
        endcase

        // While reset is held the datapath must see no strobes and
        // neutral selects, even though the state register sits in FETCH.
        if (!reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            pc_source  = 2'b00;
            illegal_op = 1'b0;
            bus_error  = 1'b0;
            retire     = 1'b0;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int WL = 8;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
    logic        alu_src_a, illegal_op, bus_error;
    logic [3:0]  state;
    logic [31:0] instr_count;

    multicycle_control #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .illegal_op(illegal_op), .bus_error(bus_error),
        .state(state), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       bus_error;
    } outs_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: an instruction is a script of steps; memory steps
    // hold until ready or until they have stalled WL cycles.
    int          step;
    int          route[$];
    int          wcnt;
    logic [31:0] cnt;
    logic [5:0]  cur_opc;
    logic [5:0]  cur_fn;

    function automatic bit jal_jr_on();
`ifdef JAL_JR_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void load_route(input logic [5:0] opc, input logic [5:0] fn);
        route.delete();
        case (opc)
            6'b100011: route = '{2, 3, 4};
            6'b101011: route = '{2, 5};
            6'b000000: if (jal_jr_on() && fn == 6'b001000) route = '{13};
                       else route = '{6, 7};
            6'b000100, 6'b000101: route = '{8};
            6'b000010: route = '{9};
            6'b001000: route = '{10, 11};
            6'b000011: if (jal_jr_on()) route = '{12};
            default: ;
        endcase
    endfunction

    function automatic outs_t table_out(input int s);
        outs_t o = '0;
        case (s)
            0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; end
            1:  o.alu_src_b = 2'b11;
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3:  begin o.mem_read = 1; o.iord = 1; end
            4:  begin o.reg_write = 1; o.mem_to_reg = 2'b01; end
            5:  begin o.mem_write = 1; o.iord = 1; end
            6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            7:  begin o.reg_write = 1; o.reg_dst = 2'b01; end
            8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01; end
            9:  begin o.pc_source = 2'b10; o.pc_write = 1; end
            10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            11: o.reg_write = 1;
            12: begin o.reg_write = 1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
                      o.pc_source = 2'b10; o.pc_write = 1; end
            13: begin o.pc_source = 2'b11; o.pc_write = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic outs_t observed();
        return {pc_write, ir_write, iord, mem_read, mem_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
                illegal_op, bus_error};
    endfunction

    function automatic void finish_step();
        if (step == 0) step = 1;
        else if (route.size() == 0) begin cnt = cnt + 1; step = 0; end
        else step = route.pop_front();
    endfunction

    task automatic model_reset();
        step = 0; wcnt = 0; cnt = 0; route.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("rst_outs", 64'(observed()), 64'(outs_t'('0)));
        check("rst_state", 64'(state), 64'd0);
        check("rst_icount", 64'(instr_count), 64'd0);
        model_reset();
    endtask

    task automatic cycle(input logic rdy, input logic zr);
        outs_t exp;
        bit    illegal;
        bit    is_mem;
        bit    tmo;
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = rdy;
        zero      = zr;
        opcode    = cur_opc;
        funct     = cur_fn;
        #1;
        illegal = 0;
        if (step == 1) begin
            load_route(cur_opc, cur_fn);
            illegal = (route.size() == 0);
        end
        is_mem = (step == 0 || step == 3 || step == 5);
        tmo    = is_mem && !rdy && (wcnt == WL - 1);
        exp = table_out(step);
        if (step == 0) begin exp.ir_write = rdy; exp.pc_write = rdy; end
        if (step == 8) exp.pc_write = (cur_opc == 6'b000100) ? zr : ~zr;
        exp.illegal_op = illegal;
        exp.bus_error  = tmo;
        check("outs", 64'(observed()), 64'(exp));
        check("state", 64'(state), 64'(step));
        check("icount", 64'(instr_count), 64'(cnt));
        check("rw_excl", 64'(mem_read & mem_write), 64'd0);
        if (is_mem) begin
            if (rdy) begin wcnt = 0; finish_step(); end
            else if (tmo) begin wcnt = 0; step = 0; route.delete(); end
            else wcnt++;
        end else if (illegal) step = 0;
        else finish_step();
    endtask

    task automatic set_instr(input logic [5:0] opc, input logic [5:0] fn);
        cur_opc = opc; cur_fn = fn;
    endtask

    logic [5:0] opc_pool [9];
    int         rmode;
    logic       rdy_r;
    logic [31:0] cnt_before;

    initial begin
        reset = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        opcode = '0; funct = '0;
        cur_opc = '0; cur_fn = '0;
        model_reset();
        opc_pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                     6'b000010, 6'b001000, 6'b000011, 6'b111111};

        do_reset();

        // lw with memory always ready: states 0,1,2,3,4
        set_instr(6'b100011, 6'd0);
        cnt_before = cnt;
        repeat (5) cycle(1'b1, 1'b0);
        check("lw_retired", 64'(cnt), 64'(cnt_before + 1));

        // reset in the middle of MEM_READ, then a clean fetch
        repeat (3) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        do_reset();
        repeat (5) cycle(1'b1, 1'b0);

        // beq taken / not taken, bne taken
        set_instr(6'b000100, 6'd0);
        cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
        set_instr(6'b000101, 6'd0);
        cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);

        // sw timing out, then sw completing on the last allowed cycle
        set_instr(6'b101011, 6'd0);
        cnt_before = cnt;
        repeat (3) cycle(1'b1, 1'b0);
        repeat (WL) cycle(1'b0, 1'b0);
        check("sw_tmo_count", 64'(cnt), 64'(cnt_before));
        check("sw_tmo_step", 64'(step), 64'd0);
        repeat (3) cycle(1'b1, 1'b0);
        repeat (WL - 1) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check("sw_late_count", 64'(cnt), 64'(cnt_before + 1));

        // fetch timeout retries
        repeat (WL) cycle(1'b0, 1'b0);

        // illegal opcode, jal, jr, r-type, addi, j
        set_instr(6'b111111, 6'd0);
        repeat (2) cycle(1'b1, 1'b0);
        set_instr(6'b000011, 6'd0);
        repeat (3) cycle(1'b1, 1'b0);
        set_instr(6'b000000, 6'b001000);
        repeat (3) cycle(1'b1, 1'b0);
        set_instr(6'b000000, 6'b100000);
        repeat (4) cycle(1'b1, 1'b0);
        set_instr(6'b001000, 6'd0);
        repeat (4) cycle(1'b1, 1'b0);
        set_instr(6'b000010, 6'd0);
        repeat (3) cycle(1'b1, 1'b0);

        // randomized traffic
        rmode = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            if (step == 0 && wcnt == 0) begin
                if ($urandom_range(0, 5) == 0)
                    set_instr(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
                else
                    set_instr(opc_pool[$urandom_range(0, 8)],
                              ($urandom_range(0, 2) == 0) ? 6'b001000
                                                          : 6'($urandom_range(0, 63)));
                rmode = $urandom_range(0, 9);
            end
            if (rmode == 0)      rdy_r = 1'b0;
            else if (rmode == 1) rdy_r = ($urandom_range(0, 7) == 0);
            else                 rdy_r = ($urandom_range(0, 3) != 0);
            cycle(rdy_r, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
